// File: rtl/vector_register_file.sv
// Vector register file: DEPTH entries of LANES x W bits, one lane-masked
// write port, two registered read ports and a sequential clear-all engine.
//
// Optional feature macro: VRF_BYPASS_EN
//   defined   - a read of the entry being written on the same edge returns
//               the merged (post-write) value
//   undefined - that read returns the pre-write contents
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   we_i         write request
//   waddr_i      write entry index
//   wmask_i      per-lane write enable (bit i -> bits [i*W +: W])
//   wdata_i      write data
//   raddr_a_i    read port A entry index
//   raddr_b_i    read port B entry index
//   rdata_a_o    registered read data, port A
//   rdata_b_o    registered read data, port B
//   clr_start_i  start a clear-all sequence
//   busy_o       high while entries are being cleared
//   clr_done_o   one-cycle pulse when the clear completes
module vector_register_file #(
  parameter int unsigned W     = 8,
  parameter int unsigned LANES = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [LANES-1:0]   wmask_i,
  input  logic [W*LANES-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_a_i,
  input  logic [AW-1:0]      raddr_b_i,
  output logic [W*LANES-1:0] rdata_a_o,
  output logic [W*LANES-1:0] rdata_b_o,
  input  logic               clr_start_i,
  output logic               busy_o,
  output logic               clr_done_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StClear = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam bit Pow2 = (DEPTH == (1 << AW));

  logic [W*LANES-1:0] mem_q [DEPTH];
  logic [W*LANES-1:0] mem_d [DEPTH];
  logic [W*LANES-1:0] rdata_a_q, rdata_a_d;
  logic [W*LANES-1:0] rdata_b_q, rdata_b_d;
  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;

  logic               wr_in_range, ra_in_range, rb_in_range;
  logic               wr_acc;
  logic [W*LANES-1:0] wr_merged;

  // With a power-of-two depth every index is valid; otherwise indices at or
  // beyond DEPTH are treated as holes (writes dropped, reads return zero).
  if (Pow2) begin : g_pow2
    assign wr_in_range = 1'b1;
    assign ra_in_range = 1'b1;
    assign rb_in_range = 1'b1;
  end else begin : g_npow2
    assign wr_in_range = (32'(waddr_i) < DEPTH);
    assign ra_in_range = (32'(raddr_a_i) < DEPTH);
    assign rb_in_range = (32'(raddr_b_i) < DEPTH);
  end

  assign busy_o     = (state_q == StClear);
  assign clr_done_o = (state_q == StDone);
  assign rdata_a_o  = rdata_a_q;
  assign rdata_b_o  = rdata_b_q;

  assign wr_acc = we_i && !busy_o && wr_in_range;

  // Post-write value of the addressed entry: masked lanes from wdata.
  always_comb begin
    wr_merged = wr_in_range ? mem_q[waddr_i] : '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (wmask_i[i]) wr_merged[i*W +: W] = wdata_i[i*W +: W];
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_acc) mem_d[waddr_i] = wr_merged;
    // Writes are never accepted while clearing, so the two never collide.
    if (state_q == StClear) mem_d[cnt_q] = '0;
  end

  always_comb begin
    rdata_a_d = ra_in_range ? mem_q[raddr_a_i] : '0;
    rdata_b_d = rb_in_range ? mem_q[raddr_b_i] : '0;
`ifdef VRF_BYPASS_EN
    if (wr_acc && (raddr_a_i == waddr_i)) rdata_a_d = wr_merged;
    if (wr_acc && (raddr_b_i == waddr_i)) rdata_b_d = wr_merged;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (clr_start_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      state_q   <= StIdle;
      cnt_q     <= '0;
    end else begin
      mem_q     <= mem_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_vector_register_file.sv
module tb_vector_register_file;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         we = 1'b0;
  logic [3:0]   waddr = '0;
  logic [15:0]  wmask = '0;
  logic [127:0] wdata = '0;
  logic [3:0]   raddr_a = '0;
  logic [3:0]   raddr_b = '0;
  logic [127:0] rdata_a, rdata_b;
  logic         clr_start = 1'b0;
  logic         busy, clr_done;

  int vectors = 0;
  int miscompares = 0;

  vector_register_file #(.W(8), .LANES(16), .DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .we_i       (we),
    .waddr_i    (waddr),
    .wmask_i    (wmask),
    .wdata_i    (wdata),
    .raddr_a_i  (raddr_a),
    .raddr_b_i  (raddr_b),
    .rdata_a_o  (rdata_a),
    .rdata_b_o  (rdata_b),
    .clr_start_i(clr_start),
    .busy_o     (busy),
    .clr_done_o (clr_done)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    logic saw_done;
    logic [127:0] exp_b;

    // Reset
    step();
    step();
    chk("rst_rdata_a", rdata_a, '0);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_clr_done", 128'(clr_done), 128'(0));
    rst = 1'b0;

    // All entries read zero after reset
    for (int i = 0; i < 16; i++) begin
      raddr_a = 4'(i);
      raddr_b = 4'(15 - i);
      step();
      chk("init_a", rdata_a, '0);
      chk("init_b", rdata_b, '0);
    end

    // Full write then single-lane overwrite
    we = 1'b1; waddr = 4'd3; wmask = 16'hFFFF;
    wdata = 128'h00112233445566778899AABBCCDDEEFF;
    step();
    wmask = 16'h0001; wdata = {16{8'h55}};
    step();
    we = 1'b0; raddr_a = 4'd3; raddr_b = 4'd3;
    step();
    chk("lane_mask_a", rdata_a, 128'h00112233445566778899AABBCCDDEE55);
    chk("same_addr_b", rdata_b, 128'h00112233445566778899AABBCCDDEE55);

    // Zero mask changes nothing
    we = 1'b1; waddr = 4'd3; wmask = 16'h0000; wdata = '1;
    step();
    we = 1'b0;
    step();
    chk("zero_mask", rdata_a, 128'h00112233445566778899AABBCCDDEE55);

    // Same-edge write and read of entry 5
    we = 1'b1; waddr = 4'd5; wmask = 16'h00FF; wdata = {16{8'hAA}}; raddr_b = 4'd5;
    step();
`ifdef VRF_BYPASS_EN
    exp_b = 128'h0000000000000000AAAAAAAAAAAAAAAA;
`else
    exp_b = '0;
`endif
    chk("same_edge_rd", rdata_b, exp_b);
    we = 1'b0;
    step();
    chk("after_write_rd", rdata_b, 128'h0000000000000000AAAAAAAAAAAAAAAA);

    // Fill every entry with nonzero data
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; waddr = 4'(i); wmask = 16'hFFFF; wdata = {16{8'(i + 1)}};
      step();
    end
    we = 1'b0; raddr_a = 4'd9;
    step();
    chk("fill_rd", rdata_a, {16{8'h0A}});

    // Clear-all with a write to entry 2 dropped mid-clear
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    n = 0;
    saw_done = 1'b0;
    while (busy && n < 40) begin
      n++;
      saw_done |= clr_done;
      if (n == 8) begin
        we = 1'b1; waddr = 4'd2; wmask = 16'hFFFF; wdata = {16{8'h77}};
      end else begin
        we = 1'b0;
      end
      step();
    end
    we = 1'b0;
    chk("busy_cycles", 128'(n), 128'(16));
    chk("no_early_done", 128'(saw_done), 128'(0));
    chk("clr_done_pulse", 128'(clr_done), 128'(1));
    step();
    chk("clr_done_low", 128'(clr_done), 128'(0));
    chk("busy_low", 128'(busy), 128'(0));
    for (int i = 0; i < 16; i++) begin
      raddr_a = 4'(i);
      step();
      chk("cleared_rd", rdata_a, '0);
    end

    // Write and clr_start on the same edge: write lands, then gets cleared
    we = 1'b1; waddr = 4'd7; wmask = 16'hFFFF; wdata = {16{8'h3C}}; clr_start = 1'b1;
    raddr_a = 4'd7;
    step();
    we = 1'b0; clr_start = 1'b0;
    step();
    chk("start_write_rd", rdata_a, {16{8'h3C}});
    n = 0;
    while (!clr_done && n < 40) begin
      n++;
      step();
    end
    chk("start_write_done", 128'(clr_done), 128'(1));
    step();
    chk("start_write_cleared", rdata_a, '0);

    // Reset aborts an in-progress clear
    we = 1'b1; waddr = 4'd12; wmask = 16'hFFFF; wdata = {16{8'hC3}};
    step();
    we = 1'b0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    #1;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_done", 128'(clr_done), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    raddr_a = 4'd12; raddr_b = 4'd15;
    for (int i = 0; i < 20; i++) begin
      step();
      saw_done |= clr_done;
    end
    chk("abort_no_done", 128'(saw_done), 128'(0));
    chk("abort_busy_after", 128'(busy), 128'(0));
    chk("abort_entry12", rdata_a, '0);
    chk("abort_entry15", rdata_b, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
